// File: rtl/time_cnt_sync.sv
// Local 64-bit time counter that follows EtherCAT SYNC0 edges: the first
// armed edge loads the counter, later edges slew it by one step or hard-load it.
module time_cnt_sync #(
    parameter int unsigned CYCLE_BITS = 9,
    parameter int unsigned SYNC_TOL   = 2
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  SYNC0,
    input  logic [63:0]           SYNC_TIME,
    input  logic                  SYNC_TIME_SET,
    input  logic                  CLR_ERR,
    output logic [63:0]           TIME_CNT,
    output logic [CYCLE_BITS-1:0] CYCLE_CNT,
    output logic                  SYNCED,
    output logic                  DRIFT_ERR,
    output logic [15:0]           LAST_DRIFT
);

    localparam int unsigned TW = 64;
    localparam int unsigned DW = 16;

    localparam logic signed [TW-1:0] TOL_P   = $signed(TW'(SYNC_TOL));
    localparam logic signed [TW-1:0] TOL_N   = -TOL_P;
    localparam logic signed [TW-1:0] SAT_MAX = 64'sd32767;
    localparam logic signed [TW-1:0] SAT_MIN = -64'sd32768;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [TW-1:0]   time_q, time_d;
    logic [TW-1:0]   pend_q, pend_d;
    logic            armed_q, armed_d;
    logic            synced_q, synced_d;
    logic            err_q, err_d;
    logic [DW-1:0]   last_q, last_d;
    logic            s1_q, s1_d;
    logic            s2_q, s2_d;
    logic            prev_q, prev_d;

    logic                 sync_edge;
    logic signed [TW-1:0] drift;
    logic                 in_tol;
    logic [DW-1:0]        drift_sat;
    logic [TW-1:0]        slew_step;

    // Edge detect and drift evaluation against the value the counter would reach
    always_comb begin
        sync_edge = s2_q & ~prev_q;
        drift     = $signed(pend_q - (time_q + TW'(1)));
        in_tol    = (drift <= TOL_P) && (drift >= TOL_N);

        if (drift > SAT_MAX) begin
            drift_sat = 16'h7fff;
        end else if (drift < SAT_MIN) begin
            drift_sat = 16'h8000;
        end else begin
            drift_sat = DW'(drift);
        end

        if (drift > 64'sd0) begin
            slew_step = TW'(2);
        end else if (drift < 64'sd0) begin
            slew_step = TW'(0);
        end else begin
            slew_step = TW'(1);
        end
    end

    always_comb begin
        s1_d     = SYNC0;
        s2_d     = s1_q;
        prev_d   = s2_q;
        state_d  = state_q;
        time_d   = time_q + TW'(1);
        pend_d   = pend_q;
        armed_d  = armed_q;
        synced_d = synced_q;
        err_d    = err_q;
        last_d   = last_q;

        if (CLR_ERR) begin
            err_d = 1'b0;
        end

        if (sync_edge && armed_q) begin
            armed_d = 1'b0;
            last_d  = drift_sat;
            if (state_q == ST_IDLE) begin
                time_d   = pend_q;
                state_d  = ST_RUN;
                synced_d = 1'b1;
            end else if (in_tol) begin
                time_d = time_q + slew_step;
            end else begin
                time_d = pend_q;
                err_d  = 1'b1;
            end
        end

        // A new pending value is taken after the edge has used the old one
        if (SYNC_TIME_SET) begin
            pend_d  = SYNC_TIME;
            armed_d = 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= ST_IDLE;
            time_q   <= '0;
            pend_q   <= '0;
            armed_q  <= 1'b0;
            synced_q <= 1'b0;
            err_q    <= 1'b0;
            last_q   <= '0;
            s1_q     <= 1'b1;
            s2_q     <= 1'b1;
            prev_q   <= 1'b1;
        end else begin
            state_q  <= state_d;
            time_q   <= time_d;
            pend_q   <= pend_d;
            armed_q  <= armed_d;
            synced_q <= synced_d;
            err_q    <= err_d;
            last_q   <= last_d;
            s1_q     <= s1_d;
            s2_q     <= s2_d;
            prev_q   <= prev_d;
        end
    end

    assign TIME_CNT   = time_q;
    assign CYCLE_CNT  = time_q[CYCLE_BITS-1:0];
    assign SYNCED     = synced_q;
    assign DRIFT_ERR  = err_q;
    assign LAST_DRIFT = last_q;

endmodule

// File: tb/tb_time_cnt_sync.sv
// Directed bench for time_cnt_sync: free run, first sync, slew, hard load,
// coincident strobes, ignored edges, reset with SYNC0 high and 64-bit wrap.
module tb_time_cnt_sync;

    logic        clk;
    logic        rst;
    logic        sync0;
    logic [63:0] sync_time;
    logic        sync_time_set;
    logic        clr_err;
    logic [63:0] time_cnt;
    logic [8:0]  cycle_cnt;
    logic        synced;
    logic        drift_err;
    logic [15:0] last_drift;

    int          n_vec;
    int          n_err;
    logic [63:0] exp_t;

    time_cnt_sync #(.CYCLE_BITS(9), .SYNC_TOL(2)) dut (
        .CLK          (clk),
        .RST          (rst),
        .SYNC0        (sync0),
        .SYNC_TIME    (sync_time),
        .SYNC_TIME_SET(sync_time_set),
        .CLR_ERR      (clr_err),
        .TIME_CNT     (time_cnt),
        .CYCLE_CNT    (cycle_cnt),
        .SYNCED       (synced),
        .DRIFT_ERR    (drift_err),
        .LAST_DRIFT   (last_drift)
    );

    always #5 clk = ~clk;

    // One clock with the free-running model advanced
    task automatic step();
        @(posedge clk); #1;
        exp_t = exp_t + 64'd1;
    endtask

    // Arm a pending value and pulse SYNC0; returns with sync_edge active
    task automatic arm_edge(input logic [63:0] pend);
        sync_time = pend; sync_time_set = 1'b1;
        step();
        sync_time_set = 1'b0; sync0 = 1'b1;
        step();
        sync0 = 1'b0;
        step();
        n_vec++;
        if (time_cnt !== exp_t) begin
            n_err++; $display("FAIL pre_edge: got %h exp %h", time_cnt, exp_t);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; sync0 = 1'b0; sync_time = '0; sync_time_set = 1'b0; clr_err = 1'b0;
        repeat (5) begin @(posedge clk); #1; end
        n_vec++; if (time_cnt !== 64'd0) begin n_err++; $display("FAIL rst_time: got %h exp 0", time_cnt); end
        n_vec++; if (synced !== 1'b0) begin n_err++; $display("FAIL rst_synced: got %b exp 0", synced); end
        n_vec++; if (drift_err !== 1'b0) begin n_err++; $display("FAIL rst_err: got %b exp 0", drift_err); end
        n_vec++; if (last_drift !== 16'd0) begin n_err++; $display("FAIL rst_last: got %h exp 0", last_drift); end
        rst = 1'b0;
        exp_t = '0;
    endtask

    task automatic test_free_run();
        repeat (100) step();
        n_vec++; if (time_cnt !== 64'd100) begin n_err++; $display("FAIL free_time: got %0d exp 100", time_cnt); end
        n_vec++; if (cycle_cnt !== 9'd100) begin n_err++; $display("FAIL free_cycle: got %0d exp 100", cycle_cnt); end
        n_vec++; if (synced !== 1'b0) begin n_err++; $display("FAIL free_synced: got %b exp 0", synced); end
        repeat (412) step();
        n_vec++; if (cycle_cnt !== 9'd0) begin n_err++; $display("FAIL free_cycle_wrap: got %0d exp 0", cycle_cnt); end
        n_vec++; if (time_cnt !== 64'd512) begin n_err++; $display("FAIL free_time_512: got %0d exp 512", time_cnt); end
    endtask

    task automatic test_ignored_idle();
        sync0 = 1'b1; step(); sync0 = 1'b0;
        repeat (3) step();
        n_vec++; if (time_cnt !== 64'd516) begin n_err++; $display("FAIL ign_idle_time: got %0d exp 516", time_cnt); end
        n_vec++; if (synced !== 1'b0) begin n_err++; $display("FAIL ign_idle_synced: got %b exp 0", synced); end
        n_vec++; if (last_drift !== 16'd0) begin n_err++; $display("FAIL ign_idle_last: got %h exp 0", last_drift); end
    endtask

    task automatic test_first_sync();
        logic [15:0] exp_last;
        arm_edge(64'h1000);
        exp_last = 16'(64'h1000 - (exp_t + 64'd1));
        @(posedge clk); #1;
        exp_t = 64'h1000;
        n_vec++; if (time_cnt !== 64'h1000) begin n_err++; $display("FAIL first_load: got %h exp 1000", time_cnt); end
        n_vec++; if (synced !== 1'b1) begin n_err++; $display("FAIL first_synced: got %b exp 1", synced); end
        n_vec++; if (drift_err !== 1'b0) begin n_err++; $display("FAIL first_err: got %b exp 0", drift_err); end
        n_vec++; if (last_drift !== exp_last) begin n_err++; $display("FAIL first_last: got %h exp %h", last_drift, exp_last); end
        step();
        n_vec++; if (time_cnt !== 64'h1001) begin n_err++; $display("FAIL first_next: got %h exp 1001", time_cnt); end
    endtask

    task automatic test_slew();
        longint      drifts [3] = '{2, -1, -2};
        logic [63:0] adv    [3] = '{64'd2, 64'd0, 64'd0};
        logic [63:0] x;
        for (int i = 0; i < 3; i++) begin
            arm_edge(exp_t + 64'd4 + drifts[i]);
            x = exp_t;
            @(posedge clk); #1;
            exp_t = x + adv[i];
            n_vec++; if (time_cnt !== exp_t) begin n_err++; $display("FAIL slew_time[%0d]: got %h exp %h", i, time_cnt, exp_t); end
            n_vec++; if (last_drift !== 16'(drifts[i])) begin n_err++; $display("FAIL slew_last[%0d]: got %h exp %h", i, last_drift, 16'(drifts[i])); end
            n_vec++; if (drift_err !== 1'b0) begin n_err++; $display("FAIL slew_err[%0d]: got %b exp 0", i, drift_err); end
        end
    endtask

    task automatic test_hard_load();
        longint      drifts [4] = '{-100, 3, 70000, -70000};
        logic [15:0] lasts  [4] = '{16'hff9c, 16'h0003, 16'h7fff, 16'h8000};
        logic [63:0] pend;
        for (int i = 0; i < 4; i++) begin
            pend = exp_t + 64'd4 + drifts[i];
            arm_edge(pend);
            clr_err = (i == 1);
            @(posedge clk); #1;
            clr_err = 1'b0;
            exp_t = pend;
            n_vec++; if (time_cnt !== pend) begin n_err++; $display("FAIL hard_time[%0d]: got %h exp %h", i, time_cnt, pend); end
            n_vec++; if (drift_err !== 1'b1) begin n_err++; $display("FAIL hard_err[%0d]: got %b exp 1", i, drift_err); end
            n_vec++; if (last_drift !== lasts[i]) begin n_err++; $display("FAIL hard_last[%0d]: got %h exp %h", i, last_drift, lasts[i]); end
            clr_err = 1'b1; step(); clr_err = 1'b0;
            n_vec++; if (drift_err !== 1'b0) begin n_err++; $display("FAIL hard_clr[%0d]: got %b exp 0", i, drift_err); end
        end
    endtask

    task automatic test_coincident_set();
        logic [63:0] x;
        arm_edge(exp_t + 64'd5);
        x = exp_t;
        sync_time = x + 64'd4; sync_time_set = 1'b1;
        @(posedge clk); #1;
        sync_time_set = 1'b0;
        exp_t = x + 64'd2;
        n_vec++; if (time_cnt !== exp_t) begin n_err++; $display("FAIL coin_old_time: got %h exp %h", time_cnt, exp_t); end
        n_vec++; if (last_drift !== 16'd1) begin n_err++; $display("FAIL coin_old_last: got %h exp 0001", last_drift); end
        sync0 = 1'b1; step(); sync0 = 1'b0; step();
        @(posedge clk); #1;
        n_vec++; if (time_cnt !== x + 64'd4) begin n_err++; $display("FAIL coin_new_time: got %h exp %h", time_cnt, x + 64'd4); end
        n_vec++; if (last_drift !== 16'hffff) begin n_err++; $display("FAIL coin_new_last: got %h exp ffff", last_drift); end
        n_vec++; if (drift_err !== 1'b0) begin n_err++; $display("FAIL coin_new_err: got %b exp 0", drift_err); end
        exp_t = x + 64'd4;
    endtask

    task automatic test_ignored_run();
        sync0 = 1'b1; step(); sync0 = 1'b0;
        repeat (3) step();
        n_vec++; if (time_cnt !== exp_t) begin n_err++; $display("FAIL ign_run_time: got %h exp %h", time_cnt, exp_t); end
        n_vec++; if (last_drift !== 16'hffff) begin n_err++; $display("FAIL ign_run_last: got %h exp ffff", last_drift); end
        n_vec++; if (synced !== 1'b1) begin n_err++; $display("FAIL ign_run_synced: got %b exp 1", synced); end
    endtask

    task automatic test_reset_sync_high();
        sync0 = 1'b1; rst = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        n_vec++; if (synced !== 1'b0) begin n_err++; $display("FAIL rsth_synced: got %b exp 0", synced); end
        n_vec++; if (time_cnt !== 64'd0) begin n_err++; $display("FAIL rsth_time0: got %h exp 0", time_cnt); end
        rst = 1'b0; exp_t = '0;
        sync_time = 64'h5555; sync_time_set = 1'b1;
        step();
        sync_time_set = 1'b0;
        repeat (5) step();
        n_vec++; if (time_cnt !== 64'd6) begin n_err++; $display("FAIL rsth_noload: got %h exp 6", time_cnt); end
        n_vec++; if (synced !== 1'b0) begin n_err++; $display("FAIL rsth_synced2: got %b exp 0", synced); end
        sync0 = 1'b0; step(); step();
    endtask

    task automatic test_wrap();
        arm_edge(64'hffff_ffff_ffff_fffe);
        @(posedge clk); #1;
        n_vec++; if (time_cnt !== 64'hffff_ffff_ffff_fffe) begin n_err++; $display("FAIL wrap_load: got %h exp fffffffffffffffe", time_cnt); end
        n_vec++; if (cycle_cnt !== 9'h1fe) begin n_err++; $display("FAIL wrap_cycle_fe: got %h exp 1fe", cycle_cnt); end
        n_vec++; if (synced !== 1'b1) begin n_err++; $display("FAIL wrap_synced: got %b exp 1", synced); end
        n_vec++; if (drift_err !== 1'b0) begin n_err++; $display("FAIL wrap_err: got %b exp 0", drift_err); end
        @(posedge clk); #1;
        n_vec++; if (time_cnt !== 64'hffff_ffff_ffff_ffff) begin n_err++; $display("FAIL wrap_ff: got %h exp ffffffffffffffff", time_cnt); end
        @(posedge clk); #1;
        n_vec++; if (time_cnt !== 64'd0) begin n_err++; $display("FAIL wrap_zero: got %h exp 0", time_cnt); end
        n_vec++; if (cycle_cnt !== 9'd0) begin n_err++; $display("FAIL wrap_cycle0: got %h exp 0", cycle_cnt); end
    endtask

    initial begin
        clk = 1'b0; n_vec = 0; n_err = 0; exp_t = '0;
        rst = 1'b1; sync0 = 1'b0; sync_time = '0; sync_time_set = 1'b0; clr_err = 1'b0;
        test_reset();
        test_free_run();
        test_ignored_idle();
        test_first_sync();
        test_slew();
        test_hard_load();
        test_coincident_set();
        test_ignored_run();
        test_reset_sync_high();
        test_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/time_cnt_sync.md
TIME_CNT_SYNC -- requirements
Module: time_cnt_sync

Interface
REQ-001 Parameter CYCLE_BITS, default 9: log2 of the ultrasound period in CLK cycles (512 cycles = 40 kHz at 20.48 MHz).
REQ-002 Parameter SYNC_TOL, default 2: largest |drift| (in CLK cycles) that is corrected by slewing rather than by a hard load.
REQ-003 CLK  in  1  single clock; all logic is on posedge CLK.
REQ-004 RST  in  1  synchronous, active-high reset.
REQ-005 SYNC0  in  1  EtherCAT sync pulse, asynchronous to CLK.
REQ-006 SYNC_TIME  in  64  time value due at the next SYNC0 edge.
REQ-007 SYNC_TIME_SET  in  1  one-cycle strobe that latches SYNC_TIME as the pending value.
REQ-008 CLR_ERR  in  1  one-cycle strobe that clears DRIFT_ERR.
REQ-009 TIME_CNT  out  64  local time counter in CLK cycles.
REQ-010 CYCLE_CNT  out  CYCLE_BITS  TIME_CNT[CYCLE_BITS-1:0], combinational.
REQ-011 SYNCED  out  1  high once the first sync load has occurred.
REQ-012 DRIFT_ERR  out  1  sticky flag: the last out-of-tolerance event forced a hard load.
REQ-013 LAST_DRIFT  out  16  signed drift of the last consumed sync edge, saturated to [-32768, 32767].

Function
REQ-014 SYNC0 SHALL pass through a 2-flop synchronizer followed by a rising-edge detector (prev register); sync_edge SHALL be asserted in the 3rd CLK cycle after the first posedge that samples SYNC0 high.
REQ-015 TIME_CNT SHALL increment by 1 every cycle, modulo 2^64, in every state unless a load or slew applies.
REQ-016 SYNC_TIME_SET SHALL copy SYNC_TIME into the pending register and set armed.
REQ-017 States SHALL be IDLE (never synced) and RUN; RST SHALL force IDLE.
REQ-018 A sync_edge while armed=0 SHALL be ignored: no change to state, TIME_CNT, LAST_DRIFT or DRIFT_ERR.
REQ-019 A sync_edge while armed=1 consumes the pending value:
- armed clears.
- drift = pending - (TIME_CNT + 1), 64-bit two's complement, interpreted as signed.
- LAST_DRIFT takes the saturated drift.
REQ-020 Consumed edge in IDLE SHALL load TIME_CNT <= pending, go to RUN and set SYNCED=1; DRIFT_ERR SHALL stay unchanged.
REQ-021 Consumed edge in RUN with |drift| <= SYNC_TOL SHALL set TIME_CNT <= TIME_CNT + 1 + clamp(drift, -1, +1), a one-step slew.
REQ-022 Consumed edge in RUN with |drift| > SYNC_TOL SHALL load TIME_CNT <= pending and set DRIFT_ERR=1.
REQ-023 Load and slew SHALL be visible on TIME_CNT in the cycle after the sync_edge clock edge, i.e. 3 CLK edges after SYNC0 is first sampled high.
REQ-024 SYNC_TIME_SET in the same cycle as a consumed sync_edge: the edge SHALL use the old pending value, and the new value is latched with armed left set.
REQ-025 SYNC_TIME_SET in the same cycle as an ignored edge (armed=0): the new value SHALL be latched and armed set; the edge stays ignored.
REQ-026 CLR_ERR SHALL clear DRIFT_ERR; if CLR_ERR and a DRIFT_ERR-setting event occur in the same cycle, set SHALL win.
REQ-027 SYNCED SHALL stay 1 in RUN until RST.

Reset
REQ-028 RST SHALL set: TIME_CNT=0, state=IDLE, pending=0, armed=0, SYNCED=0, DRIFT_ERR=0, LAST_DRIFT=0.
REQ-029 RST SHALL set both synchronizer flops and the prev register to 1, so SYNC0 held high through reset release generates no edge.
REQ-030 RST asserted mid-operation SHALL discard armed/pending, and any edge in the synchronizer pipeline SHALL be lost.

Verification
REQ-031 Free run: RST 5 cycles, release, wait 100 cycles -> TIME_CNT=100, CYCLE_CNT=100, SYNCED=0; wait 412 more -> CYCLE_CNT=0.
REQ-032 First sync: SET SYNC_TIME=0x1000, then pulse SYNC0 -> TIME_CNT=0x1000 at the REQ-023 cycle, then 0x1001; SYNCED=1; DRIFT_ERR=0.
REQ-033 Slew: in RUN, arm pending = expected+2 (drift +2) -> TIME_CNT advances by 2 on that cycle; LAST_DRIFT=2; DRIFT_ERR=0. Repeat with drift -1 -> counter holds one cycle; LAST_DRIFT=-1.
REQ-034 Hard load: in RUN, arm drift -100 -> TIME_CNT=pending, LAST_DRIFT=-100, DRIFT_ERR=1; pulse CLR_ERR -> DRIFT_ERR=0. Arm drift +70000 -> LAST_DRIFT=32767.
REQ-035 Edge cases:
- SYNC0 pulse with armed=0 -> TIME_CNT keeps incrementing, LAST_DRIFT unchanged.
- SYNC_TIME_SET coincident with a consumed edge -> the old value is used and the new value stays armed.
- SYNC0 held high across RST release -> no load.
REQ-036 Wrap: first-sync load of 0xFFFF_FFFF_FFFF_FFFE -> next two cycles 0xFFFF_FFFF_FFFF_FFFF, then 0; CYCLE_CNT=0 at the wrap.
